cdc_egress_framer: RTL and testbench

//  Sits in the clk_b domain directly downstream of the CDC FIFO and consumes its valid_b/data_b bursts.

---
 rtl/cdc_egress_framer.sv | 151 +++++++++++++++
 tb/tb_cdc_egress_framer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cdc_egress_framer.sv
// cdc_egress_framer: frames CDC FIFO egress words as SYNC header, payload, checksum trailer
// Input is staged one word deep so a frame's final word can be tagged last on an idle gap.
module cdc_egress_framer #(
  parameter int WIDTH = 8,
  parameter int BUF_DEPTH = 32,
  parameter int MAX_LEN = 16,
  parameter int GAP_CYCLES = 4,
  parameter logic [WIDTH-1:0] SYNC = 8'hA5
) (
  input  logic             clk_b,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sof,
  output logic             out_eof,
  output logic             overflow,
  output logic [15:0]      drop_cnt,
  output logic [15:0]      frame_cnt
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int GW = $clog2(GAP_CYCLES) + 1;
  localparam logic [AW:0] DEPTH_ALL = BUF_DEPTH[AW:0];
  localparam logic [AW:0] DEPTH_DATA = DEPTH_ALL - 1'b1;
  localparam logic [LW-1:0] LEN_LAST = LW'(MAX_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, HDR, PAY, TRL} state_t;
  logic [WIDTH:0] mem [BUF_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic stg_v;
  logic [WIDTH-1:0] stg_d;
  logic [GW-1:0] gap_cnt;
  logic [LW-1:0] len;
  logic push, push_last, push_ok, pop, empty, acc, cur_last, last_n, v_n, sof_n, eof_n, done;
  logic [WIDTH-1:0] sum, sum_n, d_n;
  logic [WIDTH:0] head;
  state_t state, state_n;
  assign empty = count == '0;
  assign push = stg_v && (valid_in || gap_cnt == GAP_LAST);
  assign push_last = !valid_in || len == LEN_LAST;
  // the top slot is reserved so a frame can always be closed
  assign push_ok = push && (push_last ? count < DEPTH_ALL : count < DEPTH_DATA);
  assign head = mem[rp];
  assign acc = out_valid && out_ready;
  always_ff @(posedge clk_b) begin
    if (push_ok) mem[wp] <= {push_last, stg_d};
  end
  always_ff @(posedge clk_b) begin
    if (!rst_n) begin
      stg_v <= 1'b0;
      stg_d <= '0;
      gap_cnt <= '0;
      len <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (valid_in) begin
        stg_v <= 1'b1;
        stg_d <= data_in;
        gap_cnt <= '0;
      end else if (push) begin
        stg_v <= 1'b0;
        gap_cnt <= '0;
      end else if (stg_v) gap_cnt <= gap_cnt + 1'b1;
      if (push_ok) begin
        wp <= wp + 1'b1;
        len <= push_last ? '0 : len + 1'b1;
      end
      if (push && !push_ok) begin
        overflow <= 1'b1;
        drop_cnt <= (drop_cnt == 16'hFFFF) ? drop_cnt : drop_cnt + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
    end
  end
  always_comb begin
    state_n = state;
    pop = 1'b0;
    v_n = out_valid;
    d_n = out_data;
    sof_n = out_sof;
    eof_n = out_eof;
    last_n = cur_last;
    sum_n = sum;
    done = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        v_n = 1'b1;
        d_n = SYNC;
        sof_n = 1'b1;
        eof_n = 1'b0;
        sum_n = '0;
        state_n = HDR;
      end
      HDR: if (acc) begin
        pop = 1'b1;
        d_n = head[WIDTH-1:0];
        last_n = head[WIDTH];
        sof_n = 1'b0;
        sum_n = sum + head[WIDTH-1:0];
        state_n = PAY;
      end
      PAY: if (acc && cur_last) begin
        d_n = sum;
        eof_n = 1'b1;
        state_n = TRL;
      end else if ((acc || !out_valid) && !empty) begin
        pop = 1'b1;
        v_n = 1'b1;
        d_n = head[WIDTH-1:0];
        last_n = head[WIDTH];
        sum_n = sum + head[WIDTH-1:0];
      end else if (acc) v_n = 1'b0;
      default: if (acc) begin
        v_n = 1'b0;
        eof_n = 1'b0;
        done = 1'b1;
        state_n = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk_b) begin
    if (!rst_n) begin
      state <= IDLE;
      out_valid <= 1'b0;
      out_data <= '0;
      out_sof <= 1'b0;
      out_eof <= 1'b0;
      cur_last <= 1'b0;
      sum <= '0;
      frame_cnt <= '0;
    end else begin
      state <= state_n;
      out_valid <= v_n;
      out_data <= d_n;
      out_sof <= sof_n;
      out_eof <= eof_n;
      cur_last <= last_n;
      sum <= sum_n;
      frame_cnt <= frame_cnt + {15'd0, done};
    end
  end
endmodule

// File: tb/tb_cdc_egress_framer.sv
// tb_cdc_egress_framer: directed stimulus with a queue scoreboard checked by an output monitor
module tb_cdc_egress_framer;
  logic clk_b = 1'b0, rst_n = 1'b0, valid_in = 1'b0, out_ready = 1'b0;
  logic [7:0] data_in = '0;
  logic out_valid, out_sof, out_eof, overflow;
  logic [7:0] out_data;
  logic [15:0] drop_cnt, frame_cnt;
  logic [9:0] q[$];
  logic [9:0] held, e;
  logic prev_stall = 1'b0;
  int total = 0, passes = 0, pay_seen = 0, mode = 0;

  cdc_egress_framer dut (
    .clk_b(clk_b), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sof(out_sof), .out_eof(out_eof), .overflow(overflow),
    .drop_cnt(drop_cnt), .frame_cnt(frame_cnt)
  );

  always #5 clk_b = ~clk_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ready pattern: 0 always ready, 1 alternate 1/0, 2 never ready
  initial forever begin
    @(posedge clk_b);
    #1;
    out_ready = (mode == 1) ? ~out_ready : (mode == 0);
  end

  always @(negedge clk_b) begin
    if (!rst_n) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", {out_valid, out_sof, out_eof, out_data}, {1'b1, held});
      prev_stall = out_valid && !out_ready;
      held = {out_sof, out_eof, out_data};
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_word", {out_sof, out_eof, out_data}, 10'h3FF);
        else begin
          e = q.pop_front();
          chk("out_word", {out_sof, out_eof, out_data}, e);
        end
        if (!out_sof && !out_eof) pay_seen++;
      end
    end
  end

  task automatic exp_frame(input logic [7:0] first, input int n);
    logic [7:0] s;
    s = 8'h00;
    q.push_back({2'b10, 8'hA5});
    for (int i = 0; i < n; i++) begin
      q.push_back({2'b00, first + 8'(i)});
      s = s + first + 8'(i);
    end
    q.push_back({2'b01, s});
  endtask

  task automatic word(input logic [7:0] d);
    @(posedge clk_b);
    #1;
    valid_in = 1'b1;
    data_in = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_b);
      #1;
      valid_in = 1'b0;
    end
  endtask

  task automatic burst(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) word(first + 8'(i));
  endtask

  task automatic drain;
    int t;
    t = 0;
    while (q.size() != 0 && t < 2000) begin
      @(posedge clk_b);
      t++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    repeat (4) @(posedge clk_b);
    #1;
  endtask

  initial begin
    int t;
    repeat (2) @(posedge clk_b);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    // short burst closed by the idle gap
    exp_frame(8'h01, 3);
    burst(8'h01, 3);
    idle(8);
    drain();
    chk("t1_frame_cnt", frame_cnt, 1);
    chk("t1_drop_cnt", drop_cnt, 0);
    // MAX_LEN cut followed by a gap-closed remainder
    exp_frame(8'h00, 16);
    exp_frame(8'h10, 4);
    burst(8'h00, 20);
    idle(8);
    drain();
    chk("t2_frame_cnt", frame_cnt, 3);
    // same traffic under alternating backpressure
    mode = 1;
    exp_frame(8'h00, 16);
    exp_frame(8'h10, 4);
    burst(8'h00, 20);
    idle(8);
    drain();
    mode = 0;
    chk("t3_frame_cnt", frame_cnt, 5);
    // buffer fills while stalled: 1F is the 16th word of frame two and takes the reserved slot
    mode = 2;
    exp_frame(8'h00, 16);
    exp_frame(8'h10, 16);
    burst(8'h00, 40);
    idle(6);
    chk("t4_drop_cnt", drop_cnt, 8);
    chk("t4_overflow", overflow, 1);
    mode = 0;
    drain();
    chk("t4_frame_cnt", frame_cnt, 7);
    // reset in the middle of a frame
    mode = 2;
    exp_frame(8'h00, 10);
    burst(8'h00, 10);
    idle(6);
    pay_seen = 0;
    mode = 0;
    t = 0;
    while (pay_seen < 5 && t < 200) begin
      @(posedge clk_b);
      t++;
    end
    chk("t5_pay_seen", pay_seen, 5);
    #1;
    rst_n = 1'b0;
    @(posedge clk_b);
    #1;
    rst_n = 1'b1;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_frame_cnt", frame_cnt, 0);
    chk("t5_drop_cnt", drop_cnt, 0);
    chk("t5_overflow", overflow, 0);
    exp_frame(8'h01, 1);
    burst(8'h01, 1);
    idle(8);
    drain();
    chk("t5_frame_after", frame_cnt, 1);
    // a word landing on the gap-close cycle keeps the frame open
    exp_frame(8'h01, 3);
    burst(8'h01, 2);
    idle(3);
    word(8'h03);
    idle(8);
    drain();
    chk("t6_frame_cnt", frame_cnt, 2);
    chk("t6_drop_cnt", drop_cnt, 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
